// File: rtl/hazard_pkg.sv
// Shared defaults and sizing helpers for the load-use hazard scoreboard.
package hazard_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int LOAD_LAT_DEFAULT = 1;

    // Counter must be able to hold LOAD_LAT itself.
    function automatic int lock_cnt_width(input int load_lat);
        return $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_reg_lock.sv
// One register's lock timer: loads LOAD_LAT on a load issue, clears on a
// superseding write or flush, otherwise counts down to zero and holds.
module hazard_reg_lock
    import hazard_pkg::*;
#(
    parameter  int LOAD_LAT = LOAD_LAT_DEFAULT,
    localparam int CNT_W    = lock_cnt_width(LOAD_LAT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic clear_i,
    output logic pending_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(LOAD_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register lock timers drive a combinational
// stall for the ID stage, plus a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_REGS    = NUM_REGS_DEFAULT,
    parameter  int LOAD_LAT    = LOAD_LAT_DEFAULT,
    parameter  int STALL_CNT_W = 16,
    localparam int IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_writes,
    input  logic                   issue_is_load,
    input  logic [IDX_W-1:0]       issue_dest,
    input  logic [IDX_W-1:0]       src_rs,
    input  logic [IDX_W-1:0]       src_rt,
    input  logic                   uses_rs,
    input  logic                   uses_rt,
    input  logic                   flush,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    pending,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic accept;
    logic wr_load;
    logic wr_alu;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall looks only at pre-issue lock state, so a load reading its own
    // destination never blocks itself.
    assign stall   = !flush && ((uses_rs && pending[src_rs]) || (uses_rt && pending[src_rt]));
    assign accept  = issue_valid && !stall && !flush;
    assign wr_load = accept && issue_writes && issue_is_load;
    assign wr_alu  = accept && issue_writes && !issue_is_load;

    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_lock
        logic hit;
        assign hit = (issue_dest == IDX_W'(r));

        hazard_reg_lock #(
            .LOAD_LAT (LOAD_LAT)
        ) u_lock (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_i    (wr_load && hit),
            .clear_i   (flush || (wr_alu && hit)),
            .pending_o (pending[r])
        );
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: two scoreboards (LOAD_LAT=1 and LOAD_LAT=3 with a 4-bit
// stall counter) share stimulus and are compared against a ready-time model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_writes, issue_is_load;
    logic [4:0]  issue_dest, src_rs, src_rt;
    logic        uses_rs, uses_rt, flush;

    logic        stall1, stall3;
    logic [31:0] pend1, pend3;
    logic [15:0] sc1;
    logic [3:0]  sc3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a register is locked while the current cycle is before its ready cycle.
    int ready_at [2][32];
    int sc_m     [2];
    int lat_m    [2] = '{1, 3};
    int cap_m    [2] = '{65535, 15};
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut1 (
        .clk, .rst_n, .issue_valid, .issue_writes, .issue_is_load, .issue_dest,
        .src_rs, .src_rt, .uses_rs, .uses_rt, .flush,
        .stall(stall1), .pending(pend1), .stall_count(sc1)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .STALL_CNT_W(4)) dut3 (
        .clk, .rst_n, .issue_valid, .issue_writes, .issue_is_load, .issue_dest,
        .src_rs, .src_rt, .uses_rs, .uses_rt, .flush,
        .stall(stall3), .pending(pend3), .stall_count(sc3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_pend(input int s, input int r);
        return (r != 0) && (cyc < ready_at[s][r]);
    endfunction

    function automatic logic [31:0] m_pvec(input int s);
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_pend(s, r);
        return v;
    endfunction

    function automatic logic m_stall(input int s);
        if (flush) return 1'b0;
        return (uses_rs && m_pend(s, int'(src_rs))) || (uses_rt && m_pend(s, int'(src_rt)));
    endfunction

    function automatic void m_edge(input int s, input logic st);
        int nc = cyc + 1;
        if (st && sc_m[s] < cap_m[s]) sc_m[s]++;
        if (flush) begin
            for (int r = 0; r < 32; r++) ready_at[s][r] = 0;
        end else if (issue_valid && !st && issue_writes && issue_dest != 0) begin
            ready_at[s][issue_dest] = issue_is_load ? nc + lat_m[s] : nc;
        end
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 2; s++) begin
            sc_m[s] = 0;
            for (int r = 0; r < 32; r++) ready_at[s][r] = 0;
        end
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic iv, iw, il, input int d, rs, rt,
                        input logic ur, ut, fl);
        logic s1, s3;
        issue_valid = iv; issue_writes = iw; issue_is_load = il;
        issue_dest = 5'(d); src_rs = 5'(rs); src_rt = 5'(rt);
        uses_rs = ur; uses_rt = ut; flush = fl;
        #1;
        s1 = m_stall(0);
        s3 = m_stall(1);
        check("stall_l1", stall1, s1);
        check("stall_l3", stall3, s3);
        @(posedge clk);
        m_edge(0, s1);
        m_edge(1, s3);
        cyc++;
        #1;
        check("pending_l1", pend1, m_pvec(0));
        check("pending_l3", pend3, m_pvec(1));
        check("stall_count_l1", sc1, sc_m[0]);
        check("stall_count_l3", sc3, sc_m[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_l1"}, stall1, 0);
        check({tag, "_stall_l3"}, stall3, 0);
        check({tag, "_pending_l1"}, pend1, 0);
        check({tag, "_pending_l3"}, pend3, 0);
        check({tag, "_count_l1"}, sc1, 0);
        check({tag, "_count_l3"}, sc3, 0);
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        issue_valid = 0; issue_writes = 0; issue_is_load = 0; issue_dest = 0;
        src_rs = 5'd3; src_rt = 5'd0; uses_rs = 1'b1; uses_rt = 1'b0; flush = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load to r3, then a dependent reader: 1 stall at L=1, 3 at L=3.
        step(1, 1, 1, 3, 0, 0, 0, 0, 0);
        check("load_r3_pend_l1", pend1[3], 1);
        check("load_r3_pend_l3", pend3[3], 1);
        repeat (4) step(1, 0, 0, 0, 3, 0, 1, 0, 0);
        check("dep_count_l1", sc1, 1);
        check("dep_count_l3", sc3, 3);

        // Younger ALU write to r4 supersedes the load.
        step(1, 1, 1, 4, 0, 0, 0, 0, 0);
        step(1, 1, 0, 4, 0, 0, 0, 0, 0);
        check("alu_clear_l1", pend1[4], 0);
        check("alu_clear_l3", pend3[4], 0);

        // r0 never locks.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("r0_pend_l3", pend3, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);

        // Load reading its own destination issues without stalling.
        step(1, 1, 1, 6, 6, 0, 1, 0, 0);
        check("self_src_pend_l3", pend3[6], 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Flush one cycle after a load to r7.
        step(1, 1, 1, 7, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 0, 1, 0, 1);
        check("flush_pend_l3", pend3, 0);

        // Reset asserted mid-countdown clears everything asynchronously.
        step(1, 1, 1, 7, 0, 0, 0, 0, 0);
        #2;
        src_rs = 5'd7; uses_rs = 1'b1; issue_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_reset();
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        step(1, 0, 0, 0, 7, 0, 1, 0, 0);

        // 21 forced stalls saturate the 4-bit counter.
        repeat (7) begin
            step(1, 1, 1, 5, 0, 0, 0, 0, 0);
            repeat (3) step(1, 0, 0, 0, 0, 5, 0, 1, 0);
        end
        check("sat_count_l3", sc3, 15);
        check("sat_count_l1", sc1, 7);

        // Random traffic over a small register window to provoke hazards.
        repeat (400) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
